pattern_checker: RTL

PATTERN_CHECKER -- requirements
Module: pattern_checker

---
 rtl/pattern_checker.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pattern_checker.sv
// Pattern checker FSM: checks player key presses against a stored sequence and drives a box drawer.
// Optional press timeout under macro PATTERN_TIMEOUT_EN; all outputs are decoded from registered state.
module pattern_checker #(
    parameter int NUM_KEYS       = 4,
    parameter int MAX_LEVEL      = 16,
    parameter int TIMEOUT_CYCLES = 250000000,
    localparam int KW            = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1,
    localparam int LW            = $clog2(MAX_LEVEL + 1)
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic                   iStart,
    input  logic [LW-1:0]          iLevel,
    input  logic [MAX_LEVEL*KW-1:0] iPattern,
    input  logic [NUM_KEYS-1:0]    iKeyn,
    input  logic                   iBoxDone,
    output logic                   oBoxReq,
    output logic [KW-1:0]          oBoxKey,
    output logic                   oBoxErase,
    output logic [LW-1:0]          oIndex,
    output logic                   oLost,
    output logic                   oDone
);

    if (NUM_KEYS < 2 || NUM_KEYS > 8 || MAX_LEVEL < 1 || MAX_LEVEL > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pattern_checker: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE, WAIT_PRESS, DRAW, WAIT_RELEASE, ERASE, LOST, DONE
    } state_t;

    state_t              state;
    logic [LW-1:0]       level_q;
    logic [LW-1:0]       index_q;
    logic [KW-1:0]       key_q;

    logic [NUM_KEYS-1:0] pressed;
    logic                none_low;
    logic                one_low;
    logic [KW-1:0]       press_key;
    logic [KW-1:0]       exp_key;
    logic [LW-1:0]       start_level;
    logic [LW-1:0]       index_nxt;

`ifdef PATTERN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        pressed   = ~iKeyn;
        none_low  = (pressed == '0);
        one_low   = $onehot(pressed);
        press_key = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (pressed[k]) press_key = KW'(k);
        end
        exp_key = '0;
        for (int i = 0; i < MAX_LEVEL; i++) begin
            if (index_q == LW'(i)) exp_key = iPattern[i*KW +: KW];
        end
        start_level = (iLevel > LW'(MAX_LEVEL)) ? LW'(MAX_LEVEL) : iLevel;
        index_nxt   = index_q + LW'(1);
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state   <= IDLE;
            level_q <= '0;
            index_q <= '0;
            key_q   <= '0;
`ifdef PATTERN_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        if (iLevel == '0) begin
                            state <= DONE;
                        end else begin
                            level_q <= start_level;
                            index_q <= '0;
                            state   <= WAIT_PRESS;
`ifdef PATTERN_TIMEOUT_EN
                            to_cnt  <= '0;
`endif
                        end
                    end
                end
                WAIT_PRESS: begin
                    // A press of any kind in the same cycle wins over the timeout.
                    if (none_low) begin
`ifdef PATTERN_TIMEOUT_EN
                        if (to_hit) state <= LOST;
                        else        to_cnt <= to_cnt + TW'(1);
`endif
                    end else if (one_low && press_key == exp_key) begin
                        key_q <= press_key;
                        state <= DRAW;
                    end else begin
                        state <= LOST;
                    end
                end
                DRAW: begin
                    if (iBoxDone) state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (none_low) state <= ERASE;
                end
                ERASE: begin
                    if (iBoxDone) begin
                        index_q <= index_nxt;
                        if (index_nxt == level_q) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT_PRESS;
`ifdef PATTERN_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                        end
                    end
                end
                LOST:    state <= IDLE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign oBoxReq   = (state == DRAW) || (state == ERASE);
    assign oBoxErase = (state == ERASE);
    assign oBoxKey   = key_q;
    assign oIndex    = index_q;
    assign oLost     = (state == LOST);
    assign oDone     = (state == DONE);

endmodule
